// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
//   RA_W         register address width
//   FWD_*        EX operand forwarding select encodings
//   REG_RA       link register index written by JAL
//   stage_t      destination sideband carried alongside a pipeline stage
package cpu_pkg;

  localparam int RA_W = 5;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  localparam logic [RA_W-1:0] REG_RA = 5'd31;

  typedef struct packed {
    logic            v;
    logic            wreg;
    logic [RA_W-1:0] dst;
    logic            lw;
  } stage_t;

endpackage

// File: rtl/hazard_match.sv
// Producer/consumer register comparator.
//   v, wreg  producer stage holds a valid register-writing instruction
//   dst      producer destination register
//   src      consumer source register
//   hit      consumer needs the producer's result ($0 never matches)
module hazard_match #(
  parameter int W = 5
) (
  input  logic         v,
  input  logic         wreg,
  input  logic [W-1:0] dst,
  input  logic [W-1:0] src,
  output logic         hit
);

  assign hit = v & wreg & (dst == src) & (src != '0);

endmodule

// File: rtl/hazard_ctl.sv
// Interlock and forwarding controller for the 5-stage MIPS pipeline.
// Shadows EX/MEM/WB destination sideband and derives stall, bubble,
// flush and forwarding selects from the ID-stage decode.
//   clk, rst_n            clock, async active-low reset
//   ext_stall             freezes the whole pipeline
//   id_*                  ID-stage decode (sources, uses, destination, BJ, jump)
//   stall_if_id           hold PC and IF/ID
//   bubble_ex             load a NOP into ID/EX
//   flush_if_id           squash IF/ID on the next edge
//   fwd_ex_a/b            EX operand select (regfile / EX/MEM / MEM/WB)
//   fwd_id_a/b            ID compare operand taken from EX/MEM
//   stall_cnt             saturating count of hazard-stall cycles
module hazard_ctl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ext_stall,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_br_rs,
  input  logic             id_br_rt,
  input  logic             id_wreg,
  input  logic [RA_W-1:0]  id_wdst,
  input  logic             id_lw,
  input  logic             id_bj,
  input  logic             id_jump,
  output logic             stall_if_id,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic [1:0]       fwd_ex_a,
  output logic [1:0]       fwd_ex_b,
  output logic             fwd_id_a,
  output logic             fwd_id_b,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int NUM_OPS = 2;  // operand 0 = rs, operand 1 = rt

  stage_t                       ex_q, mem_q;
  logic [NUM_OPS-1:0][RA_W-1:0] ex_src;
  logic [NUM_OPS-1:0]           ex_use;
  logic                         wb_v, wb_wreg;
  logic [RA_W-1:0]              wb_dst;

  logic [NUM_OPS-1:0][RA_W-1:0] id_src;
  logic [NUM_OPS-1:0]           id_use, id_br;
  logic [NUM_OPS-1:0]           hit_id_ex, hit_id_mem, hit_ex_mem, hit_ex_wb;
  logic [NUM_OPS-1:0][1:0]      fwd_ex;
  logic [NUM_OPS-1:0]           fwd_id;
  logic                         hz_lu, hz_br, hz;

  assign id_src = {id_rt, id_rs};
  assign id_use = {id_use_rt, id_use_rs};
  assign id_br  = {id_br_rt, id_br_rs};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    hazard_match #(.W(RA_W)) u_id_ex (
      .v(ex_q.v), .wreg(ex_q.wreg), .dst(ex_q.dst), .src(id_src[i]), .hit(hit_id_ex[i]));
    hazard_match #(.W(RA_W)) u_id_mem (
      .v(mem_q.v), .wreg(mem_q.wreg), .dst(mem_q.dst), .src(id_src[i]), .hit(hit_id_mem[i]));
    hazard_match #(.W(RA_W)) u_ex_mem (
      .v(mem_q.v), .wreg(mem_q.wreg), .dst(mem_q.dst), .src(ex_src[i]), .hit(hit_ex_mem[i]));
    hazard_match #(.W(RA_W)) u_ex_wb (
      .v(wb_v), .wreg(wb_wreg), .dst(wb_dst), .src(ex_src[i]), .hit(hit_ex_wb[i]));

    // A load in MEM has no data yet, so its match falls through to WB/regfile.
    always_comb begin
      fwd_ex[i] = FWD_REG;
      if (ex_use[i] & hit_ex_mem[i] & ~mem_q.lw)
        fwd_ex[i] = FWD_EXMEM;
      else if (ex_use[i] & hit_ex_wb[i])
        fwd_ex[i] = FWD_MEMWB;
    end

    assign fwd_id[i] = id_br[i] & hit_id_mem[i] & ~mem_q.lw & ~hz;
  end

  // Compares in ID need the value a cycle earlier than EX does: any EX producer
  // stalls once, a load stalls again while it sits in MEM.
  assign hz_lu = id_valid & ex_q.lw & |((id_use | id_br) & hit_id_ex);
  assign hz_br = |(id_br & (hit_id_ex | (hit_id_mem & {NUM_OPS{mem_q.lw}})));
  assign hz    = hz_lu | hz_br;

  // ext_stall is a raw input, so gate with rst_n to keep outputs quiet in reset.
  assign stall_if_id = rst_n & (hz | ext_stall);
  assign bubble_ex   = rst_n & hz & ~ext_stall;
  assign flush_if_id = rst_n & id_valid & (id_bj | id_jump) & ~hz & ~ext_stall;
  assign fwd_ex_a    = fwd_ex[0];
  assign fwd_ex_b    = fwd_ex[1];
  assign fwd_id_a    = fwd_id[0];
  assign fwd_id_b    = fwd_id[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      ex_src    <= '0;
      ex_use    <= '0;
      mem_q     <= '0;
      wb_v      <= 1'b0;
      wb_wreg   <= 1'b0;
      wb_dst    <= '0;
      stall_cnt <= '0;
    end else if (!ext_stall) begin
      wb_v    <= mem_q.v;
      wb_wreg <= mem_q.wreg;
      wb_dst  <= mem_q.dst;
      mem_q   <= ex_q;
      if (hz) begin
        ex_q   <= '0;
        ex_src <= '0;
        ex_use <= '0;
      end else begin
        ex_q   <= '{v: id_valid, wreg: id_wreg, dst: id_wdst, lw: id_lw};
        ex_src <= id_src;
        ex_use <= id_use;
      end
      if (hz && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_ctl.md
Name: hazard_ctl

Overview:
- Pipeline interlock and forwarding controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Consumes the ID-stage control decode (WREG, LW, JR, J, JAL, BJ, register fields) and keeps its own shadow copy of EX/MEM/WB destination sideband.
- Generates per-cycle stall, bubble, flush and forwarding selects, and maintains a hazard-stall performance counter.
- Branches and JR resolve in ID.

Parameters:
- RA_W, 5, register address width
- CNT_W, 16, width of stall performance counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ext_stall  in  1  memory/system busy; freezes the whole pipeline
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  RA_W  ID source registers
- id_use_rs, id_use_rt  in  1  ID instruction reads rs / rt in EX
- id_br_rs, id_br_rt  in  1  ID instruction reads rs / rt in ID (beq/bne: both; JR: rs only)
- id_wreg  in  1  ID instruction writes a register
- id_wdst  in  RA_W  final destination (rd, rt or 31 already muxed)
- id_lw  in  1  ID instruction is a load
- id_bj  in  1  taken-branch result (BJ)
- id_jump  in  1  J, JAL or JR
- stall_if_id  out  1  hold PC and IF/ID register
- bubble_ex  out  1  load NOP into ID/EX
- flush_if_id  out  1  squash IF/ID on the next edge
- fwd_ex_a, fwd_ex_b  out  2  EX operand select: 0 regfile, 1 EX/MEM, 2 MEM/WB
- fwd_id_a, fwd_id_b  out  1  ID compare operand from EX/MEM
- stall_cnt  out  CNT_W  count of hazard-stall cycles, saturating

Behaviour:
- State: ex_{v,wreg,dst,lw,rs,rt,use_rs,use_rt}, mem_{v,wreg,dst,lw}, wb_{v,wreg,dst}, stall_cnt.
- Async reset clears all state to 0. While rst_n=0 every output is 0.
- Match rule: X matches stage S iff S_v & S_wreg & S_dst==X & X!=0. $0 never matches.
- Load-use stall (hz_lu): id_valid & ex_lw & match on (id_use_rs&rs or id_use_rt&rt or id_br_rs&rs or id_br_rt&rt).
- Branch stall (hz_br), for id_br_* operands only:
  - match EX (any writer), or
  - match MEM with mem_lw=1.
  - Result: an ALU producer costs 1 cycle; a load producer costs 2 cycles.
- hz = hz_lu | hz_br.
- Combinational outputs, valid in the same cycle:
  - stall_if_id = hz | ext_stall.
  - bubble_ex = hz & ~ext_stall.
  - flush_if_id = id_valid & (id_bj | id_jump) & ~hz & ~ext_stall.
  - fwd_ex_a: 1 if ex_use_rs & match(ex_rs, MEM) & ~mem_lw; else 2 if ex_use_rs & match(ex_rs, WB); else 0. fwd_ex_b uses rt with the same rule. MEM has priority over WB.
  - fwd_id_a/b = id_br_rs/rt & match(rs/rt, MEM) & ~mem_lw & ~hz.
- WB→ID forwarding is not needed: the register file is write-before-read.
- Edge update:
  - ext_stall=1: all shadow state holds; stall_cnt holds.
  - Otherwise: wb ← mem; mem ← ex; ex ← (hz ? all-zero bubble : ID fields with v=id_valid).
- stall_cnt increments when hz & ~ext_stall, and saturates at all-ones.
- A taken branch that is also stalled does not flush. The flush happens in the cycle the stall clears.
- Simultaneous hz_lu and hz_br count one stall cycle.
- Reset mid-stall discards all in-flight sideband; the first instruction after reset sees no hazards.

Decomposition:
- Shared package (cpu_pkg):
  - FWD_REG=0, FWD_EXMEM=1, FWD_MEMWB=2
  - RA_W
  - REG_RA=31
  - stage-sideband record: v, wreg, dst, lw
- One natural sub-module: hazard_match (pure combinational valid/wreg/dst/nonzero comparator), instantiated per operand/stage pair.

Test Plan:
- add $3 in EX, then `sub $4,$3,$5` enters EX → fwd_ex_a=1, no stall. One cycle later a dependent reads $3 via WB → fwd_ex_a=2.
- `lw $2` in EX, `add $6,$2,$7` in ID → stall_if_id=1 and bubble_ex=1 for exactly 1 cycle, stall_cnt 0→1. The add then reaches EX with fwd_ex_a=2.
- `lw $8` in EX, `beq $8,$9` taken in ID → 2 stall cycles, no flush during them. On the 3rd cycle flush_if_id=1, fwd_id_a=0, stall_cnt=2.
- `add $5` in EX, then `bne $5,$0` → 1 stall cycle. Next cycle fwd_id_a=1; flush_if_id follows id_bj.
- Write to $0 in EX/MEM/WB with an ID reader of $0 → all forwards 0, no stall.
- ext_stall=1 for 3 cycles during a load-use hazard → bubble_ex=0, stall_cnt unchanged, state frozen. Deasserting rst_n mid-sequence → all outputs 0 immediately and stall_cnt=0.
